// File: rtl/zy_seg_scanner_if.sv
// Host-side bundle of the segment scanner: write controls,
// scan-rate select and the display drive outputs.
interface zy_seg_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 7,
  parameter int RATE_W     = 5
);
  logic                  rw;
  logic                  sel;
  logic [3:0]            pin_in;
  logic [RATE_W-1:0]     rate;
  logic [SEG_W-1:0]      seg_out;
  logic [NUM_DIGITS-1:0] dig_en;
  logic                  mode_o;
  logic                  pulse_o;

  modport master (
    output rw, sel, pin_in, rate,
    input  seg_out, dig_en, mode_o, pulse_o
  );

  modport slave (
    input  rw, sel, pin_in, rate,
    output seg_out, dig_en, mode_o, pulse_o
  );
endinterface

// File: rtl/zy_seg_scanner.sv
// Multi-digit segment store with nibble-wise write mode and
// a prescaled, rate-selectable multiplexed display scanner.
module zy_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 7,
  parameter int PRESCALE_W = 9,
  parameter int RATE_W     = 5
) (
  input logic             clock,
  input logic             reset,
  zy_seg_scanner_if.slave bus
);
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (SEG_W < 5 || SEG_W > 8 || NUM_DIGITS < 2) begin : g_bad_cfg
    $error("zy_seg_scanner: unsupported SEG_W or NUM_DIGITS");
  end

  typedef enum logic [1:0] {INIT, SCAN, WLO, WHI} state_t;

  state_t                state;
  state_t                state_nx;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         ptr_nx;
  logic [PW-1:0]         ptr_inc;
  logic [SEG_W-1:0]      mem [NUM_DIGITS];
  logic [PRESCALE_W-1:0] presc;
  logic [RATE_W-1:0]     rate_cnt;
  logic                  pulse;
  logic                  tick;
  logic                  hit;
  logic                  wr_lo;
  logic                  wr_hi;

  assign tick    = (presc == '0);
  assign hit     = tick && (rate_cnt == bus.rate);
  assign ptr_inc = (ptr == PW'(NUM_DIGITS - 1)) ? '0 : ptr + 1'b1;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    wr_lo    = 1'b0;
    wr_hi    = 1'b0;
    unique case (state)
      INIT: begin
        if (bus.rw) begin
          state_nx = WLO;
          ptr_nx   = '0;
        end else begin
          state_nx = SCAN;
        end
      end
      SCAN: begin
        // entering write mode beats a coincident scan pulse
        if (bus.rw) begin
          state_nx = WLO;
          ptr_nx   = '0;
        end else if (pulse) begin
          ptr_nx = ptr_inc;
        end
      end
      WLO: begin
        if (!bus.rw)     state_nx = SCAN;
        else if (bus.sel) state_nx = WHI;
        else             wr_lo = 1'b1;
      end
      WHI: begin
        if (!bus.rw) begin
          state_nx = SCAN;
        end else if (bus.sel) begin
          wr_hi = 1'b1;
        end else begin
          ptr_nx   = ptr_inc;
          state_nx = WLO;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      ptr      <= '0;
      presc    <= '0;
      rate_cnt <= '0;
      pulse    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
        mem[i] <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      presc <= presc + 1'b1;
      pulse <= hit;
      // lowering rate below rate_cnt simply wraps the counter
      if (hit)       rate_cnt <= '0;
      else if (tick) rate_cnt <= rate_cnt + 1'b1;
      if (wr_lo)
        mem[ptr][3:0] <= bus.pin_in;
      if (wr_hi)
        mem[ptr][SEG_W-1:4] <= bus.pin_in[SEG_W-5:0];
    end
  end

  assign bus.seg_out = mem[ptr];
  assign bus.dig_en  = NUM_DIGITS'(1) << ptr;
  assign bus.mode_o  = (state == WLO) || (state == WHI);
  assign bus.pulse_o = pulse;
endmodule

// File: tb/tb_zy_seg_scanner.sv
// Directed bench for zy_seg_scanner: 3 digits, 7 segments,
// prescaler period 4.
module tb_zy_seg_scanner;
  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   t0;
  int   t1;
  logic seen;

  zy_seg_scanner_if #(
    .NUM_DIGITS(3), .SEG_W(7), .RATE_W(5)
  ) bus ();

  zy_seg_scanner #(
    .NUM_DIGITS(3), .SEG_W(7),
    .PRESCALE_W(2), .RATE_W(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_pulse();
    int n;
    n = 0;
    while (bus.pulse_o !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    chk("pulse_seen", bus.pulse_o, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.rw = 1'b0;
    bus.sel = 1'b0;
    bus.pin_in = 4'h0;
    bus.rate = '0;
    step(2);
    chk("rst_seg", bus.seg_out, 0);
    chk("rst_dig", bus.dig_en, 3'b001);
    chk("rst_mode", bus.mode_o, 0);
    chk("rst_pulse", bus.pulse_o, 0);
    reset = 1'b0;

    // idle scan, rate 0: pulse every 4 cycles
    step(1);
    chk("scan_p1", bus.pulse_o, 1);
    chk("scan_d0", bus.dig_en, 3'b001);
    step(1);
    chk("scan_p1_low", bus.pulse_o, 0);
    chk("scan_d1", bus.dig_en, 3'b010);
    step(3);
    chk("scan_p2", bus.pulse_o, 1);
    step(1);
    chk("scan_d2", bus.dig_en, 3'b100);
    step(3);
    chk("scan_p3", bus.pulse_o, 1);
    step(1);
    chk("scan_wrap", bus.dig_en, 3'b001);

    // write digits 0 and 1
    bus.rw = 1'b1; bus.sel = 1'b0; bus.pin_in = 4'h5;
    step(1);
    chk("wr_mode", bus.mode_o, 1);
    chk("wr_ptr0", bus.dig_en, 3'b001);
    step(1);
    bus.sel = 1'b1; bus.pin_in = 4'h3;
    step(2);
    chk("wr_mem0", bus.seg_out, 7'h35);
    bus.sel = 1'b0; bus.pin_in = 4'hA;
    step(1);
    chk("wr_ptr1", bus.dig_en, 3'b010);
    chk("wr_adv_nowr", bus.seg_out, 7'h00);
    step(1);
    bus.sel = 1'b1; bus.pin_in = 4'h6;
    step(2);
    chk("wr_mem1", bus.seg_out, 7'h6A);
    bus.sel = 1'b0;
    step(1);
    chk("wr_ptr2", bus.dig_en, 3'b100);
    bus.rw = 1'b0;
    step(1);
    chk("exit_mode", bus.mode_o, 0);
    chk("exit_ptr", bus.dig_en, 3'b100);
    chk("exit_seg", bus.seg_out, 7'h00);
    step(1);
    chk("resume_pulse", bus.pulse_o, 1);
    step(1);
    chk("resume_d0", bus.dig_en, 3'b001);
    chk("resume_m0", bus.seg_out, 7'h35);
    step(4);
    chk("resume_d1", bus.dig_en, 3'b010);
    chk("resume_m1", bus.seg_out, 7'h6A);

    // rate 2: 12-cycle pulse period
    bus.rate = 5'd2;
    wait_pulse();
    t0 = cyc;
    chk("r2_d_at_pulse", bus.dig_en, 3'b010);
    step(1);
    chk("r2_adv1", bus.dig_en, 3'b100);
    wait_pulse();
    t1 = cyc;
    chk("r2_period", t1 - t0, 12);
    chk("r2_hold", bus.dig_en, 3'b100);
    step(1);
    chk("r2_adv2", bus.dig_en, 3'b001);

    // rw rises with a pulse while ptr = 1
    for (int k = 0; k < 5 && bus.dig_en !== 3'b010; k++) begin
      step(1);
      wait_pulse();
    end
    chk("co_ptr1", bus.dig_en, 3'b010);
    chk("co_pulse", bus.pulse_o, 1);
    bus.rw = 1'b1; bus.sel = 1'b0; bus.pin_in = 4'hF;
    step(1);
    chk("co_ptr0", bus.dig_en, 3'b001);
    chk("co_mode", bus.mode_o, 1);

    // reset in WHI mid-write
    step(1);
    bus.sel = 1'b1; bus.pin_in = 4'h7;
    step(2);
    chk("whi_mem0", bus.seg_out, 7'h7F);
    chk("whi_mode", bus.mode_o, 1);
    reset = 1'b1;
    step(1);
    chk("mrst_seg", bus.seg_out, 0);
    chk("mrst_dig", bus.dig_en, 3'b001);
    chk("mrst_mode", bus.mode_o, 0);
    chk("mrst_pulse", bus.pulse_o, 0);
    reset = 1'b0; bus.rw = 1'b0; bus.sel = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      seen = seen | bus.pulse_o;
    end
    chk("mrst_rc_quiet", seen, 0);
    step(1);
    chk("mrst_rc_pulse", bus.pulse_o, 1);
    step(1);
    chk("mrst_d1", bus.dig_en, 3'b010);
    chk("mrst_mem1", bus.seg_out, 7'h00);

    // drop rw while in WHI
    bus.rw = 1'b1; bus.sel = 1'b0; bus.pin_in = 4'h0;
    step(1);
    chk("drop_ptr0", bus.dig_en, 3'b001);
    bus.sel = 1'b1; bus.pin_in = 4'h5;
    step(1);
    chk("drop_in_whi", bus.mode_o, 1);
    bus.rw = 1'b0;
    step(1);
    chk("drop_mode", bus.mode_o, 0);
    chk("drop_ptr", bus.dig_en, 3'b001);
    chk("drop_nowr", bus.seg_out, 7'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
